wb_pipe_buffer: RTL and testbench
=================================

WB_PIPE_BUFFER -- requirements
Module: wb_pipe_buffer

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_W, 32, width of ALUresult/MEMdata.
REQ-002 SHALL have parameter RD_W, 5, destination register address width.
REQ-003 SHALL have parameter ZERO_GUARD, 1, when 1 suppress writes to register 0.
REQ-004 SHALL have one clock and a synchronous, active-low reset. Ports are listed as name, direction, width, meaning.
- clk_i, in, 1, sole clock, all state updates on posedge.
- rst_i, in, 1, synchronous active-low reset.
REQ-005 SHALL have these upstream (MEM-side) ports:
- valid_i, in, 1, payload valid.
- ready_o, out, 1, buffer can accept.
- RDaddr_i, in, RD_W, destination register.
- ALUresult_i, in, DATA_W, ALU result.
- MEMdata_i, in, DATA_W, load data.
- MemtoReg_i, in, 1, WB select.
- RegWrite_i, in, 1, WB write enable.
REQ-006 SHALL have these control port:
- flush_i, in, 1, discard all held and incoming entries.
REQ-007 SHALL have these downstream (WB-side) ports:
- valid_o, out, 1, head entry valid.
- ready_i, in, 1, WB consumes head.
- RDaddr_o, out, RD_W, head destination.
- ALUresult_o, out, DATA_W, head ALU result.
- MEMdata_o, out, DATA_W, head load data.
- MemtoReg_o, out, 1, head WB select.
- RegWrite_o, out, 1, gated write enable.
- WBdata_o, out, DATA_W, selected writeback value.
- count_o, out, 2, occupancy 0..2.

Function
REQ-008 SHALL hold two entries (head, skid), each storing {RDaddr, ALUresult, MEMdata, MemtoReg, RegWrite}.
REQ-009 SHALL implement states EMPTY, ONE, FULL. count_o SHALL be 0, 1 or 2 respectively.
REQ-010 SHALL drive ready_o = (state != FULL) && rst_i. ready_o SHALL be driven from the registered state only, with no combinational path from ready_i.
REQ-011 SHALL define handshake events: in_fire = valid_i && ready_o; out_fire = valid_o && ready_i.
REQ-012 SHALL make these transitions from EMPTY: in_fire -> ONE, head <= input; otherwise stay in EMPTY.
REQ-013 SHALL make these transitions from ONE:
- in_fire && out_fire -> ONE, head <= input.
- in_fire only -> FULL, skid <= input.
- out_fire only -> EMPTY.
- neither -> ONE, hold.
REQ-014 SHALL make these transitions from FULL: out_fire -> ONE, head <= skid; otherwise hold. Input SHALL be ignored in FULL.
REQ-015 SHALL assert valid_o = (state != EMPTY). Payload outputs SHALL come from head registers. Minimum latency SHALL be 1 cycle, input to valid_o.
REQ-016 SHALL hold payload outputs stable while valid_o && !ready_i.
REQ-017 SHALL drive RegWrite_o = head.RegWrite && valid_o && !(ZERO_GUARD && head.RDaddr == 0).
REQ-018 SHALL drive WBdata_o = MemtoReg_o ? MEMdata_o : ALUresult_o, combinationally.
REQ-019 SHALL give flush_i priority over all handshakes: next state EMPTY, with any same-cycle input discarded. Data registers SHALL be left unchanged.
REQ-020 SHALL preserve order: entries SHALL be delivered in acceptance order, never duplicated or dropped except by flush or reset.

Reset
REQ-021 SHALL, while rst_i=0 at a posedge, set state EMPTY and clear all head/skid fields to 0.
REQ-022 SHALL hold these output values during and after reset: valid_o=0, ready_o=0 while rst_i=0, RegWrite_o=0, count_o=0, WBdata_o=0.
REQ-023 SHALL give reset asserted mid-operation priority over flush and handshakes, losing all entries. ready_o SHALL return to 1 in the first cycle with rst_i=1.

Structure
REQ-024 SHALL place the state enum (EMPTY/ONE/FULL) and the entry record typedef in shared package pipe_pkg, alongside other pipeline-stage buffers.
REQ-025 SHALL use one sub-module, wb_entry_reg, for a single payload register with load enable and synchronous clear, instantiated twice.

Verification
REQ-026 SHALL cover the pass-through scenario: ready_i=1, one entry {RD=5, ALU=0x10, MEM=0xAA, MemtoReg=0, RegWrite=1} -> next cycle valid_o=1, RegWrite_o=1, WBdata_o=0x10.
REQ-027 SHALL cover the backpressure scenario: ready_i=0, push A (RD=1) then B (RD=2) -> count_o=2, ready_o=0, C ignored; then ready_i=1 -> outputs A, then B, then valid_o=0.
REQ-028 SHALL cover simultaneous in/out in ONE: head A, push B with ready_i=1 -> count_o stays 1, next head = B.
REQ-029 SHALL cover the flush-with-incoming scenario: FULL, flush_i=1 with valid_i=1 -> next cycle count_o=0, valid_o=0, RegWrite_o=0.
REQ-030 SHALL cover the zero guard: entry RD=0, RegWrite=1 -> RegWrite_o=0. With ZERO_GUARD=0 -> RegWrite_o=1.
REQ-031 SHALL cover mid-operation reset: FULL, rst_i=0 for one cycle -> count_o=0, ready_o=0 during reset, ready_o=1 the following cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and entry record for pipeline-stage buffers
package pipe_pkg;

    typedef logic [1:0] buf_state_t;

    // Encoding doubles as occupancy, so count can be read straight off the state
    localparam buf_state_t EMPTY = 2'd0;
    localparam buf_state_t ONE   = 2'd1;
    localparam buf_state_t FULL  = 2'd2;

    localparam int WB_DATA_W = 32;
    localparam int WB_RD_W   = 5;

    typedef struct packed {
        logic [WB_RD_W-1:0]   RDaddr;
        logic [WB_DATA_W-1:0] ALUresult;
        logic [WB_DATA_W-1:0] MEMdata;
        logic                 MemtoReg;
        logic                 RegWrite;
    } wb_entry_t;

    // Flat width of an entry laid out as {RDaddr, ALUresult, MEMdata, MemtoReg, RegWrite}
    function automatic int wb_entry_width(input int data_w, input int rd_w);
        return rd_w + 2 * data_w + 2;
    endfunction

endpackage

// File: rtl/wb_entry_reg.sv
// wb_entry_reg: one payload register with load enable and synchronous clear
module wb_entry_reg #(
    parameter int W = 72
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear on reset, otherwise capture only when told to
    always_ff @(posedge clk_i) begin
        if (!rst_i) q <= '0;
        else if (load) q <= d;
    end

endmodule

// File: rtl/wb_pipe_buffer.sv
// wb_pipe_buffer: two-entry skid buffer between MEM and WB stages
import pipe_pkg::*;

module wb_pipe_buffer #(
    parameter int DATA_W     = 32,
    parameter int RD_W       = 5,
    parameter bit ZERO_GUARD = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [RD_W-1:0]   RDaddr_i,
    input  logic [DATA_W-1:0] ALUresult_i,
    input  logic [DATA_W-1:0] MEMdata_i,
    input  logic              MemtoReg_i,
    input  logic              RegWrite_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [RD_W-1:0]   RDaddr_o,
    output logic [DATA_W-1:0] ALUresult_o,
    output logic [DATA_W-1:0] MEMdata_o,
    output logic              MemtoReg_o,
    output logic              RegWrite_o,
    output logic [DATA_W-1:0] WBdata_o,
    output logic [1:0]        count_o
);

    localparam int EW = wb_entry_width(DATA_W, RD_W);

    buf_state_t    state, state_nx;
    logic [EW-1:0] in_ent, head_d, head_q, skid_q;
    logic          in_fire, out_fire, head_ld, skid_ld, head_rw;

    assign in_ent   = {RDaddr_i, ALUresult_i, MEMdata_i, MemtoReg_i, RegWrite_i};
    assign ready_o  = (state != FULL) && rst_i;
    assign valid_o  = state != EMPTY;
    assign in_fire  = valid_i && ready_o;
    assign out_fire = valid_o && ready_i;

    // Head refills from the skid when draining FULL, otherwise from the input;
    // a flush leaves both data registers untouched
    assign head_ld = !flush_i && (state == FULL ? out_fire : in_fire && (state == EMPTY || out_fire));
    assign skid_ld = !flush_i && state == ONE && in_fire && !out_fire;
    assign head_d  = state == FULL ? skid_q : in_ent;

    // Occupancy transitions; flush overrides every handshake
    always_comb begin
        state_nx = flush_i         ? EMPTY :
                   state == EMPTY  ? (in_fire ? ONE : EMPTY) :
                   state == ONE    ? (in_fire && !out_fire ? FULL : !in_fire && out_fire ? EMPTY : ONE) :
                   state == FULL   ? (out_fire ? ONE : FULL) :
                                     EMPTY;
    end

    // State register; reset beats flush and handshakes
    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= EMPTY;
        else state <= state_nx;
    end

    wb_entry_reg #(.W(EW)) u_head (.clk_i(clk_i), .rst_i(rst_i), .load(head_ld), .d(head_d), .q(head_q));
    wb_entry_reg #(.W(EW)) u_skid (.clk_i(clk_i), .rst_i(rst_i), .load(skid_ld), .d(in_ent), .q(skid_q));

    assign {RDaddr_o, ALUresult_o, MEMdata_o, MemtoReg_o, head_rw} = head_q;
    assign RegWrite_o = head_rw && valid_o && !(ZERO_GUARD && RDaddr_o == '0);
    assign WBdata_o   = MemtoReg_o ? MEMdata_o : ALUresult_o;
    assign count_o    = state;

endmodule

// File: tb/tb_wb_pipe_buffer.sv
// tb_wb_pipe_buffer: queue-model scoreboard plus directed scenarios for wb_pipe_buffer
module tb_wb_pipe_buffer;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        mtr;
        logic        rw;
    } ent_t;

    logic        clk = 0;
    logic        rst_i = 0, valid_i = 0, ready_i = 0, flush_i = 0;
    logic [4:0]  rd_i = 0;
    logic [31:0] alu_i = 0, mem_i = 0;
    logic        mtr_i = 0, rw_i = 0;

    logic        ready_o, valid_o, MemtoReg_o, RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] ALUresult_o, MEMdata_o, WBdata_o;
    logic [1:0]  count_o;

    logic        z_ready_o, z_valid_o, z_MemtoReg_o, z_RegWrite_o;
    logic [4:0]  z_RDaddr_o;
    logic [31:0] z_ALUresult_o, z_MEMdata_o, z_WBdata_o;
    logic [1:0]  z_count_o;

    int   n_checks = 0, n_pass = 0;
    bit   mon_en = 0;
    ent_t q[$];
    ent_t e;

    always #5 clk = ~clk;

    wb_pipe_buffer dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .RDaddr_i(rd_i), .ALUresult_i(alu_i), .MEMdata_i(mem_i), .MemtoReg_i(mtr_i), .RegWrite_i(rw_i),
        .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .RDaddr_o(RDaddr_o),
        .ALUresult_o(ALUresult_o), .MEMdata_o(MEMdata_o), .MemtoReg_o(MemtoReg_o),
        .RegWrite_o(RegWrite_o), .WBdata_o(WBdata_o), .count_o(count_o)
    );

    wb_pipe_buffer #(.ZERO_GUARD(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(z_ready_o),
        .RDaddr_i(rd_i), .ALUresult_i(alu_i), .MEMdata_i(mem_i), .MemtoReg_i(mtr_i), .RegWrite_i(rw_i),
        .flush_i(flush_i), .valid_o(z_valid_o), .ready_i(ready_i), .RDaddr_o(z_RDaddr_o),
        .ALUresult_o(z_ALUresult_o), .MEMdata_o(z_MEMdata_o), .MemtoReg_o(z_MemtoReg_o),
        .RegWrite_o(z_RegWrite_o), .WBdata_o(z_WBdata_o), .count_o(z_count_o)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                        input logic mtr, input logic rw);
        valid_i = 1; rd_i = rd; alu_i = alu; mem_i = mem; mtr_i = mtr; rw_i = rw;
    endtask

    // Reference model: an ordered queue of at most two accepted entries
    always @(posedge clk) begin
        bit acc, del;
        acc = rst_i && valid_i && !flush_i && q.size() < 2;
        del = ready_i && q.size() != 0;
        if (!rst_i || flush_i) q.delete();
        else begin
            if (del) void'(q.pop_front());
            if (acc) q.push_back(ent_t'{rd_i, alu_i, mem_i, mtr_i, rw_i});
        end
    end

    // Monitor: compare the DUT against the head of the model queue every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", count_o, q.size());
            chk("valid", valid_o, q.size() != 0);
            chk("ready", ready_o, rst_i && q.size() < 2);
            chk("count_ng", z_count_o, q.size());
            if (q.size() != 0) begin
                e = q[0];
                chk("rd", RDaddr_o, e.rd);
                chk("alu", ALUresult_o, e.alu);
                chk("mem", MEMdata_o, e.mem);
                chk("mtr", MemtoReg_o, e.mtr);
                chk("rw", RegWrite_o, e.rw && e.rd != 0);
                chk("rw_ng", z_RegWrite_o, e.rw);
                chk("wbdata", WBdata_o, e.mtr ? e.mem : e.alu);
            end else begin
                chk("rw_idle", RegWrite_o, 0);
                chk("rw_idle_ng", z_RegWrite_o, 0);
            end
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_count", count_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 0);
        chk("rst_rw", RegWrite_o, 0);
        chk("rst_wbdata", WBdata_o, 0);
        rst_i = 1;
        #1;
        chk("rst_release_ready", ready_o, 1);
        mon_en = 1;

        ready_i = 1;
        push(5, 32'h10, 32'hAA, 0, 1);
        tick();
        valid_i = 0;
        chk("pass_valid", valid_o, 1);
        chk("pass_rw", RegWrite_o, 1);
        chk("pass_wbdata", WBdata_o, 32'h10);
        tick();
        chk("pass_drain", valid_o, 0);

        ready_i = 0;
        push(1, 32'h100, 32'h101, 1, 1);
        tick();
        push(2, 32'h200, 32'h201, 0, 1);
        tick();
        chk("bp_count", count_o, 2);
        chk("bp_ready", ready_o, 0);
        push(3, 32'h300, 32'h301, 0, 1);
        tick();
        chk("bp_c_ignored", count_o, 2);
        valid_i = 0;
        ready_i = 1;
        #1;
        chk("bp_head_a", RDaddr_o, 1);
        chk("bp_wb_a", WBdata_o, 32'h101);
        tick();
        chk("bp_head_b", RDaddr_o, 2);
        tick();
        chk("bp_empty", valid_o, 0);

        ready_i = 0;
        push(7, 32'h7, 32'h77, 0, 1);
        tick();
        ready_i = 1;
        push(8, 32'h8, 32'h88, 1, 1);
        tick();
        valid_i = 0;
        chk("sim_count", count_o, 1);
        chk("sim_head", RDaddr_o, 8);
        tick();

        ready_i = 0;
        push(3, 32'h33, 32'h333, 0, 1);
        tick();
        push(4, 32'h44, 32'h444, 0, 1);
        tick();
        chk("fl_full", count_o, 2);
        flush_i = 1;
        push(9, 32'h99, 32'h999, 0, 1);
        tick();
        flush_i = 0;
        valid_i = 0;
        chk("fl_count", count_o, 0);
        chk("fl_valid", valid_o, 0);
        chk("fl_rw", RegWrite_o, 0);

        push(0, 32'h5, 32'h6, 0, 1);
        tick();
        valid_i = 0;
        chk("zg_on", RegWrite_o, 0);
        chk("zg_off", z_RegWrite_o, 1);
        ready_i = 1;
        tick();

        ready_i = 0;
        push(11, 32'hB, 32'hBB, 0, 1);
        tick();
        push(12, 32'hC, 32'hCC, 1, 1);
        tick();
        valid_i = 0;
        chk("mr_full", count_o, 2);
        rst_i = 0;
        tick();
        chk("mr_count", count_o, 0);
        chk("mr_ready", ready_o, 0);
        chk("mr_wbdata", WBdata_o, 0);
        rst_i = 1;
        #1;
        chk("mr_ready_back", ready_o, 1);
        tick();
        chk("mr_still_empty", count_o, 0);

        for (int i = 0; i < 600; i++) begin
            valid_i = $urandom_range(0, 9) < 6;
            ready_i = $urandom_range(0, 9) < 5;
            flush_i = $urandom_range(0, 29) == 0;
            rst_i   = $urandom_range(0, 59) != 0;
            rd_i    = 5'($urandom_range(0, 31));
            alu_i   = $urandom;
            mem_i   = $urandom;
            mtr_i   = 1'($urandom_range(0, 1));
            rw_i    = 1'($urandom_range(0, 1));
            tick();
        end

        valid_i = 0; flush_i = 0; rst_i = 1; ready_i = 1;
        tick();
        tick();
        chk("final_empty", count_o, 0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
